erm16_microprocessor: RTL and testbench



---
 rtl/erm16_microprocessor.sv | 214 +++++++++++++++++++++
 tb/tb_erm16_microprocessor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/erm16_microprocessor.sv
// ERM16: 16-bit multi-cycle accumulator-style RISC core.
// FETCH/DECODE/EXEC/WB sequencer around an 8x16 register file, 16-bit ALU and flags.
module erm16_microprocessor (
  input  logic        clk,
  input  logic        init,
  input  logic [15:0] DI,
  output logic [15:0] ADDR_BUS,
  output logic [15:0] DO,
  output logic        wrmem,
  output logic        ioe,
  output logic        intreq
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_MOV  = 6'h06;
  localparam logic [5:0] OP_OUT  = 6'h07;
  localparam logic [5:0] OP_IN   = 6'h08;
  localparam logic [5:0] OP_LD   = 6'h09;
  localparam logic [5:0] OP_ST   = 6'h0A;
  localparam logic [5:0] OP_SHL  = 6'h0B;
  localparam logic [5:0] OP_SHR  = 6'h0C;
  localparam logic [5:0] OP_CMP  = 6'h0D;
  localparam logic [5:0] OP_CALL = 6'h18;
  localparam logic [5:0] OP_RET  = 6'h19;
  localparam logic [5:0] OP_INT  = 6'h1A;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, res_q, res_d;
  logic [15:0] addr_q, addr_d, do_q, do_d;
  logic [5:0]  flags_q, flags_d, nflags_q, nflags_d;
  logic        wrmem_q, wrmem_d, ioe_q, ioe_d, intreq_q, intreq_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  logic [5:0]  op;
  logic        imm_sel;
  logic [2:0]  rd, rs;
  logic [15:0] imm_ext;

  assign op      = ir_q[15:10];
  assign imm_sel = ir_q[9];
  assign rd      = ir_q[8:6];
  assign rs      = ir_q[5:3];
  assign imm_ext = {{10{ir_q[5]}}, ir_q[5:0]};

  logic [16:0] wide;
  logic [15:0] alu_res;
  logic        alu_c, alu_v;
  logic [5:0]  alu_flags;

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[15:0];
        alu_c   = wide[16];
        alu_v   = (a_q[15] == b_q[15]) && (alu_res[15] != a_q[15]);
      end
      OP_SUB, OP_CMP: begin
        // bit 16 of the widened difference is the unsigned borrow
        wide    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = wide[15:0];
        alu_c   = wide[16];
        alu_v   = (a_q[15] != b_q[15]) && (alu_res[15] != a_q[15]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = b_q;
      OP_SHL: begin
        alu_res = {a_q[14:0], 1'b0};
        alu_c   = a_q[15];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[15:1]};
        alu_c   = a_q[0];
      end
      default: ;
    endcase
  end

  assign alu_flags = {1'b0, ~^alu_res, alu_v, alu_res[15], alu_c, alu_res == 16'h0000};

  logic        take;
  logic [15:0] pc_inc, target;

  always_comb begin
    take = 1'b0;
    case (op[2:0])
      3'd0: take = 1'b1;
      3'd1: take = flags_q[0];
      3'd2: take = ~flags_q[0];
      3'd3: take = flags_q[1];
      3'd4: take = ~flags_q[1];
      3'd5: take = flags_q[2];
      3'd6: take = flags_q[3];
      default: take = 1'b0;
    endcase
  end

  assign pc_inc = pc_q + 16'd1;
  assign target = imm_sel ? pc_inc + imm_ext : a_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    addr_d   = addr_q;
    do_d     = do_q;
    flags_d  = flags_q;
    nflags_d = nflags_q;
    regs_d   = regs_q;
    wrmem_d  = 1'b0;
    ioe_d    = 1'b0;
    intreq_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = DI;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = regs_q[rd];
        b_d     = imm_sel ? imm_ext : regs_q[rs];
        state_d = S_EXEC;
        if (op inside {OP_OUT, OP_IN, OP_LD, OP_ST}) addr_d = regs_q[rs];
        if (op inside {OP_OUT, OP_ST}) do_d = regs_q[rd];
        wrmem_d  = (op == OP_ST);
        ioe_d    = (op == OP_OUT) || (op == OP_IN);
        intreq_d = (op == OP_INT);
      end
      S_EXEC: begin
        res_d    = (op inside {OP_LD, OP_IN}) ? DI : alu_res;
        nflags_d = alu_flags;
        state_d  = S_WB;
      end
      S_WB: begin
        pc_d = pc_inc;
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_SHL, OP_SHR,
                       OP_LD, OP_IN})
          regs_d[rd] = res_q;
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP})
          flags_d = nflags_q;
        if (op[5:3] == 3'b010 && take) pc_d = target;
        if (op == OP_CALL) begin
          regs_d[7] = pc_inc;
          pc_d      = target;
        end
        if (op == OP_RET) pc_d = regs_q[7];
        if (op == OP_HLT) begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end else begin
          addr_d  = pc_d;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      do_q     <= '0;
      flags_q  <= '0;
      nflags_q <= '0;
      wrmem_q  <= 1'b0;
      ioe_q    <= 1'b0;
      intreq_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      addr_q   <= addr_d;
      do_q     <= do_d;
      flags_q  <= flags_d;
      nflags_q <= nflags_d;
      wrmem_q  <= wrmem_d;
      ioe_q    <= ioe_d;
      intreq_q <= intreq_d;
      regs_q   <= regs_d;
    end
  end

  assign ADDR_BUS = addr_q;
  assign DO       = do_q;
  assign wrmem    = wrmem_q;
  assign ioe      = ioe_q;
  assign intreq   = intreq_q;
endmodule

// File: tb/tb_erm16_microprocessor.sv
// Bench for erm16_microprocessor: instruction-level reference model plus per-cycle output compare.
module tb_erm16_microprocessor;
  logic        clk  = 1'b0;
  logic        init = 1'b0;
  logic [15:0] DI   = '0;
  logic [15:0] ADDR_BUS, DO;
  logic        wrmem, ioe, intreq;

  erm16_microprocessor dut (
    .clk(clk), .init(init), .DI(DI), .ADDR_BUS(ADDR_BUS), .DO(DO),
    .wrmem(wrmem), .ioe(ioe), .intreq(intreq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_addr = '0, exp_do = '0;
  logic        exp_wr = 1'b0, exp_ioe = 1'b0, exp_int = 1'b0;
  logic        chk_en = 1'b0;

  logic [15:0] m_r [8];
  logic [15:0] m_pc, m_do, m_addr, seen_exec_addr;
  logic        mz, mc, mn, mv, mp, m_halted;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ADDR_BUS", ADDR_BUS, exp_addr);
      check("DO", DO, exp_do);
      check("wrmem", {15'b0, wrmem}, {15'b0, exp_wr});
      check("ioe", {15'b0, ioe}, {15'b0, exp_ioe});
      check("intreq", {15'b0, intreq}, {15'b0, exp_int});
    end
  end

  function automatic logic [15:0] sx6(input logic [5:0] v);
    return (v >= 6'd32) ? 16'(int'(v) - 64) : 16'(v);
  endfunction

  function automatic logic [15:0] ei(input int op, input int rd, input int imm);
    return {op[5:0], 1'b1, rd[2:0], imm[5:0]};
  endfunction

  function automatic logic [15:0] er(input int op, input int rd, input int rs);
    return {op[5:0], 1'b0, rd[2:0], rs[2:0], 3'b000};
  endfunction

  task automatic set_flags(input logic [15:0] r, input bit c, input bit v);
    mz = (r == 16'd0);
    mn = (r >= 16'h8000);
    mc = c;
    mv = v;
    mp = ($countones(r) % 2) == 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = '0; m_do = '0; m_addr = '0; m_halted = 1'b0;
    mz = 1'b0; mc = 1'b0; mn = 1'b0; mv = 1'b0; mp = 1'b0;
    exp_addr = '0; exp_do = '0; exp_wr = 1'b0; exp_ioe = 1'b0; exp_int = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic model_exec(input logic [15:0] ins, input logic [15:0] ld);
    int op, rd, rs, sa, sb, s;
    logic ii;
    bit tk;
    logic [15:0] a, b, r, pc1, tgt;
    op  = int'(ins[15:10]);
    ii  = ins[9];
    rd  = int'(ins[8:6]);
    rs  = int'(ins[5:3]);
    a   = m_r[rd];
    b   = ii ? sx6(ins[5:0]) : m_r[rs];
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    pc1 = m_pc + 16'd1;
    tgt = ii ? pc1 + sx6(ins[5:0]) : a;
    m_pc = pc1;
    tk = 1'b0;
    case (op) inside
      1: begin
        s = int'(a) + int'(b);
        r = 16'(s);
        set_flags(r, s > 65535, (sa + sb) > 32767 || (sa + sb) < -32768);
        m_r[rd] = r;
      end
      2, 13: begin
        r = a - b;
        set_flags(r, a < b, (sa - sb) > 32767 || (sa - sb) < -32768);
        if (op == 2) m_r[rd] = r;
      end
      3: begin r = a & b; set_flags(r, 1'b0, 1'b0); m_r[rd] = r; end
      4: begin r = a | b; set_flags(r, 1'b0, 1'b0); m_r[rd] = r; end
      5: begin r = a ^ b; set_flags(r, 1'b0, 1'b0); m_r[rd] = r; end
      6: m_r[rd] = b;
      8, 9: m_r[rd] = ld;
      11: begin r = 16'(int'(a) * 2); set_flags(r, a >= 16'h8000, 1'b0); m_r[rd] = r; end
      12: begin r = a / 16'd2; set_flags(r, (a % 16'd2) == 16'd1, 1'b0); m_r[rd] = r; end
      [16:23]: begin
        case (op - 16)
          0: tk = 1'b1;
          1: tk = mz;
          2: tk = !mz;
          3: tk = mc;
          4: tk = !mc;
          5: tk = mn;
          6: tk = mv;
          default: tk = 1'b0;
        endcase
        if (tk) m_pc = tgt;
      end
      24: begin m_r[7] = pc1; m_pc = tgt; end
      25: m_pc = m_r[7];
      63: begin m_halted = 1'b1; m_pc = pc1 - 16'd1; end
      default: ;
    endcase
  endtask

  // Called just after a rising edge that starts a FETCH cycle.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] ld, input bit abort_exec);
    int op, rd, rs;
    op = int'(ins[15:10]);
    rd = int'(ins[8:6]);
    rs = int'(ins[5:3]);
    exp_addr = m_addr; exp_do = m_do;
    exp_wr = 1'b0; exp_ioe = 1'b0; exp_int = 1'b0;
    DI = ins;
    @(posedge clk); #1;
    DI = 16'($urandom);
    @(posedge clk); #1;
    if (op inside {7, 8, 9, 10}) m_addr = m_r[rs];
    if (op == 7 || op == 10) m_do = m_r[rd];
    exp_addr = m_addr; exp_do = m_do;
    exp_wr  = (op == 10);
    exp_ioe = (op == 7 || op == 8);
    exp_int = (op == 26);
    DI = ld;
    seen_exec_addr = ADDR_BUS;
    if (abort_exec) begin
      init = 1'b0;
      @(posedge clk); #1;
      model_reset();
      init = 1'b1;
      return;
    end
    @(posedge clk); #1;
    exp_wr = 1'b0; exp_ioe = 1'b0; exp_int = 1'b0;
    DI = 16'($urandom);
    @(posedge clk); #1;
    model_exec(ins, ld);
    if (!m_halted) m_addr = m_pc;
    exp_addr = m_addr;
  endtask

  task automatic run_random(input int n);
    int op;
    for (int k = 0; k < n; k++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(32, 62)) : int'($urandom_range(0, 26));
      run_instr({6'(op), 10'($urandom)}, 16'($urandom), 1'b0);
    end
  endtask

  initial begin
    init = 1'b0;
    @(posedge clk); #1;
    model_reset();
    @(posedge clk); #1;
    init = 1'b1;
    check("reset_first_fetch_addr", ADDR_BUS, 16'h0000);

    run_instr(ei(6, 1, 5), 16'h0, 1'b0);
    run_instr(ei(6, 2, -3), 16'h0, 1'b0);
    run_instr(er(1, 1, 2), 16'h0, 1'b0);
    run_instr(er(7, 1, 0), 16'h0, 1'b0);
    check("out_add_result", DO, 16'h0002);
    run_instr(ei(19, 0, 1), 16'h0, 1'b0);
    check("jc_taken_target", ADDR_BUS, 16'd6);
    run_instr(ei(6, 3, 1), 16'h0, 1'b0);
    run_instr(ei(2, 3, 1), 16'h0, 1'b0);
    run_instr(ei(17, 0, 2), 16'h0, 1'b0);
    check("jz_taken_target", ADDR_BUS, 16'd11);
    run_instr(ei(18, 0, 5), 16'h0, 1'b0);
    check("jnz_not_taken", ADDR_BUS, 16'd12);
    run_instr(ei(6, 5, 16), 16'h0, 1'b0);
    run_instr(er(9, 6, 0), 16'h1234, 1'b0);
    run_instr(er(10, 6, 5), 16'h0, 1'b0);
    check("st_exec_addr", seen_exec_addr, 16'h0010);
    check("st_data", DO, 16'h1234);
    run_instr(er(9, 6, 5), 16'hBEEF, 1'b0);
    run_instr(er(7, 6, 5), 16'h0, 1'b0);
    check("ld_then_out", DO, 16'hBEEF);
    check("out_exec_addr", seen_exec_addr, 16'h0010);
    run_instr(ei(6, 4, 31), 16'h0, 1'b0);
    for (int k = 0; k < 10; k++) run_instr(er(11, 4, 0), 16'h0, 1'b0);
    run_instr(er(1, 4, 4), 16'h0, 1'b0);
    run_instr(er(7, 4, 0), 16'h0, 1'b0);
    check("overflow_sum", DO, 16'hF800);
    run_instr(ei(22, 0, 1), 16'h0, 1'b0);
    check("jv_taken", ADDR_BUS, 16'd32);
    run_instr(ei(21, 0, 1), 16'h0, 1'b0);
    check("jn_taken", ADDR_BUS, 16'd34);
    run_instr(ei(24, 0, 3), 16'h0, 1'b0);
    check("call_target", ADDR_BUS, 16'd38);
    run_instr(er(7, 7, 0), 16'h0, 1'b0);
    check("call_link_r7", DO, 16'd35);
    run_instr(er(25, 0, 0), 16'h0, 1'b0);
    check("ret_target", ADDR_BUS, 16'd35);
    run_instr(er(26, 0, 0), 16'h0, 1'b0);
    run_instr(ei(23, 0, 5), 16'h0, 1'b0);
    check("jnever_falls_through", ADDR_BUS, 16'd37);
    run_instr(er(8, 2, 1), 16'h5A5A, 1'b0);
    run_instr(er(7, 2, 0), 16'h0, 1'b0);
    check("in_then_out", DO, 16'h5A5A);

    run_random(300);

    run_instr(16'hFFFF, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      DI = 16'($urandom);
    end

    init = 1'b0;
    @(posedge clk); #1;
    model_reset();
    init = 1'b1;
    run_instr(ei(6, 5, 16), 16'h0, 1'b0);
    run_instr(ei(6, 6, -7), 16'h0, 1'b0);
    run_instr(er(10, 6, 5), 16'h0, 1'b1);
    check("abort_addr_zero", ADDR_BUS, 16'h0000);
    check("abort_do_zero", DO, 16'h0000);

    run_instr(ei(6, 1, -1), 16'h0, 1'b0);
    run_instr(er(16, 1, 0), 16'h0, 1'b0);
    check("jump_abs_ffff", ADDR_BUS, 16'hFFFF);
    run_instr(16'h0000, 16'h0, 1'b0);
    check("pc_wrap", ADDR_BUS, 16'h0000);
    run_instr(ei(16, 0, -2), 16'h0, 1'b0);
    check("rel_jump_wrap", ADDR_BUS, 16'hFFFF);
    run_instr(er(7, 5, 5), 16'h0, 1'b0);
    check("regs_cleared_by_reset", DO, 16'h0000);

    run_random(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
